// File: rtl/seq_div_16bit_pkg.sv
// Shared encodings and constants for the iterative divider.
// The clamp constants are common with the saturating add/sub.
package seq_div_16bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [15:0] SAT_POS  = 16'h7FFF;
  localparam logic [15:0] SAT_NEG  = 16'h8000;
  localparam logic [15:0] DVZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/seq_div_16bit_div_step.sv
// One restoring division step: trial subtract, keep or restore.
// Partial remainder is below the divisor, so bit WIDTH is a valid sign.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   pr_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   pr_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;

  assign trial = pr_i - {1'b0, dvs_i};
  assign q_o   = ~trial[WIDTH];
  assign pr_o  = q_o ? trial : pr_i;

endmodule

// File: rtl/seq_div_16bit.sv
// Iterative 16-bit signed/unsigned divider, one step per cycle.
// Signed overflow clamps the quotient; divide-by-zero flags dvz.
module seq_div_16bit
  import seq_div_16bit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dvz,
  output logic             sat
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   pr_q;
  logic [WIDTH-1:0] wd_q, dvs_q;
  logic             qneg_q, rneg_q;
  logic             ovf_q, dvzsel_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             busy_q, done_q;
  logic             dvz_q, sat_q;

  logic [WIDTH-1:0] dvd_abs_d, dvs_abs_d;
  logic [WIDTH:0]   pr_sh, pr_d;
  logic             qbit_d;
  logic [WIDTH-1:0] rlo, q_fix_d, r_fix_d;

  assign dvd_abs_d = (is_signed && dividend[WIDTH-1])
                   ? (~dividend + 1'b1) : dividend;
  assign dvs_abs_d = (is_signed && divisor[WIDTH-1])
                   ? (~divisor + 1'b1) : divisor;

  assign pr_sh = {pr_q[WIDTH-1:0], wd_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr_i  (pr_sh),
    .dvs_i (dvs_q),
    .pr_o  (pr_d),
    .q_o   (qbit_d)
  );

  assign rlo     = pr_q[WIDTH-1:0];
  assign q_fix_d = qneg_q ? (~wd_q + 1'b1) : wd_q;
  assign r_fix_d = rneg_q ? (~rlo + 1'b1) : rlo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pr_q     <= '0;
      wd_q     <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dvzsel_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dvz_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            dvz_q  <= 1'b0;
            sat_q  <= 1'b0;
            pr_q   <= '0;
            qneg_q <= is_signed
                    & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= is_signed & dividend[WIDTH-1];
            ovf_q  <= is_signed
                    && dividend == SAT_NEG
                    && divisor == DVZ_QUOT;
            if (divisor == '0) begin
              // raw dividend parks in wd_q for the remainder
              dvzsel_q <= 1'b1;
              wd_q     <= dividend;
              state_q  <= FIX;
            end else begin
              dvzsel_q <= 1'b0;
              wd_q     <= dvd_abs_d;
              dvs_q    <= dvs_abs_d;
              cnt_q    <= CNT_W'(WIDTH);
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          wd_q  <= {wd_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          unique case (1'b1)
            dvzsel_q: begin
              quot_q <= DVZ_QUOT;
              rem_q  <= wd_q;
              dvz_q  <= 1'b1;
            end
            ovf_q: begin
              quot_q <= SAT_POS;
              rem_q  <= '0;
              sat_q  <= 1'b1;
            end
            default: begin
              quot_q <= q_fix_d;
              rem_q  <= r_fix_d;
            end
          endcase
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dvz       = dvz_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_seq_div_16bit.sv
// Bench for seq_div_16bit: transaction-level reference model
// checked every cycle, plus directed vectors with literal results.
module tb_seq_div_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, dvz, sat;

  int ncmp = 0;
  int nbad = 0;

  seq_div_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dvz       (dvz),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dvz;
    logic        sat;
  } res_t;

  function automatic res_t ref_div(logic sgn,
                                   logic [15:0] a,
                                   logic [15:0] b);
    res_t o;
    int   sa, sb;
    o = '0;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 16'h0) begin
      o.q = 16'hFFFF;
      o.r = a;
      o.dvz = 1'b1;
    end else if (sgn) begin
      if (sa == -32768 && sb == -1) begin
        o.q = 16'h7FFF;
        o.sat = 1'b1;
      end else begin
        o.q = 16'(sa / sb);
        o.r = 16'(sa % sb);
      end
    end else begin
      o.q = a / b;
      o.r = a % b;
    end
    return o;
  endfunction

  // transaction model: accept when idle, result after fixed latency
  logic m_busy, m_done;
  int   m_left;
  res_t m_pend, m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_pend <= '0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= (divisor == 16'h0) ? 1 : 17;
        m_pend <= ref_div(is_signed, dividend, divisor);
        m_out.dvz <= 1'b0;
        m_out.sat <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    ncmp++;
    if ({quotient, remainder, dvz, sat, busy, done} !==
        {m_out, m_busy, m_done}) begin
      nbad++;
      $display("FAIL model t=%0t q=%h r=%h dvz=%b sat=%b busy=%b done=%b want q=%h r=%h dvz=%b sat=%b busy=%b done=%b",
               $time, quotient, remainder, dvz, sat, busy, done,
               m_out.q, m_out.r, m_out.dvz, m_out.sat,
               m_busy, m_done);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // call at a negedge; returns at the negedge after the start edge
  task automatic issue(logic sg, logic [15:0] a, logic [15:0] b);
    start = 1'b1;
    is_signed = sg;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string nm, logic [15:0] eq,
                           logic [15:0] er, logic ed, logic es,
                           int elat, int inj);
    int lat = 0;
    int bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (lat == inj) begin
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 16'd50;
        divisor = 16'd5;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".q"}, 32'(quotient), 32'(eq));
    chk({nm, ".r"}, 32'(remainder), 32'(er));
    chk({nm, ".dvz"}, 32'(dvz), 32'(ed));
    chk({nm, ".sat"}, 32'(sat), 32'(es));
    chk({nm, ".lat"}, 32'(lat), 32'(elat));
    chk({nm, ".busy"}, 32'(bcnt), 32'(elat));
  endtask

  task automatic op(string nm, logic sg, logic [15:0] a,
                    logic [15:0] b, logic [15:0] eq,
                    logic [15:0] er, logic ed, logic es);
    @(negedge clk);
    issue(sg, a, b);
    wait_done(nm, eq, er, ed, es, (b == 16'h0) ? 1 : 17, -1);
  endtask

  initial begin
    chk("pin.neg7by2", 34'(ref_div(1'b1, 16'hFFF9, 16'h0002)),
        32'({16'hFFFD, 16'hFFFF, 2'b00}));
    chk("pin.sat", 34'(ref_div(1'b1, 16'h8000, 16'hFFFF)),
        32'({16'h7FFF, 16'h0000, 2'b01}));

    repeat (2) @(negedge clk);
    chk("rst.out", 32'({quotient, remainder}), 32'h0);
    chk("rst.flags", 32'({busy, done, dvz, sat}), 32'h0);
    #2 rst = 1'b0;

    op("u100_7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);
    op("s_m7_2", 1'b1, 16'hFFF9, 16'h0002,
       16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
    op("s_7_m2", 1'b1, 16'h0007, 16'hFFFE,
       16'hFFFD, 16'h0001, 1'b0, 1'b0);
    op("s_sat", 1'b1, 16'h8000, 16'hFFFF,
       16'h7FFF, 16'h0000, 1'b0, 1'b1);
    op("u_8000", 1'b0, 16'h8000, 16'hFFFF,
       16'h0000, 16'h8000, 1'b0, 1'b0);
    op("s_dvz", 1'b1, 16'h04D2, 16'h0000,
       16'hFFFF, 16'h04D2, 1'b1, 1'b0);
    op("u_dvz", 1'b0, 16'h04D2, 16'h0000,
       16'hFFFF, 16'h04D2, 1'b1, 1'b0);
    op("u_ffff_1", 1'b0, 16'hFFFF, 16'h0001,
       16'hFFFF, 16'h0000, 1'b0, 1'b0);
    op("s_min_1", 1'b1, 16'h8000, 16'h0001,
       16'h8000, 16'h0000, 1'b0, 1'b0);
    op("s_m100_m7", 1'b1, 16'hFF9C, 16'hFFF9,
       16'h000E, 16'hFFFE, 1'b0, 1'b0);

    // start during busy is dropped; start in done cycle is taken
    @(negedge clk);
    issue(1'b0, 16'd100, 16'd7);
    wait_done("ign", 16'd14, 16'd2, 1'b0, 1'b0, 17, 3);
    issue(1'b0, 16'd50, 16'd5);
    wait_done("b2b", 16'd10, 16'd0, 1'b0, 1'b0, 17, -1);

    // reset mid-calculation
    @(negedge clk);
    issue(1'b0, 16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.out", 32'({quotient, remainder}), 32'h0);
    chk("abort.flags", 32'({busy, done, dvz, sat}), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("abort.nodone", 32'(done), 32'd0);
    end
    op("u9_3", 1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
